memory_access_unit: RTL and testbench
=====================================

// Module: memory_access_unit
// PURPOSE
//  Sits between the multi-cycle core controller and the external memory bus.
//  Accepts one fetch/load/store request at a time via memory_enable/memory_ready.
//  Drives a word-aligned bus with byte strobes and detects misaligned accesses.
//  Returns raw and sign/zero-extended read data with a one-cycle memory_valid pulse.
// PARAMETERS
//  RESPONSE_TIMEOUT  64  cycles waiting for bus_rsp_valid before access fault; 0 disables timeout
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  memory_enable  in   1   request strobe; sampled only while memory_ready=1
//  memory_command in   1   0 = read, 1 = write
//  address        in   32  byte address
//  write_data     in   32  store data (low bytes significant)
//  access_type    in   3   funct3: [1:0] 00=byte, 01=half, 1x=word; [2]=1 zero-extend load
//  force_word     in   1   instruction fetch: overrides access_type, forces word read
//  memory_ready   out  1   unit idle; a request may be issued this cycle
//  memory_valid   out  1   one-cycle pulse: access complete
//  read_word      out  32  raw bus word, valid with memory_valid (instruction path)
//  load_data      out  32  lane-shifted, extended load result, valid with memory_valid
//  access_fault   out  1   pulses with memory_valid on timeout; read_word/load_data are 0
//  misaligned_exception out 1  combinational: half && addr[0], or word && addr[1:0]!=0
//  bus_req        out  1   request held until bus_gnt
//  bus_we         out  1   write request
//  bus_addr       out  32  {address[31:2],2'b00}
//  bus_wstrb      out  4   byte strobes; 0000 on reads
//  bus_wdata      out  32  lane-replicated store data
//  bus_gnt        in   1   bus accepts the request this cycle
//  bus_rsp_valid  in   1   response or write ack; bus_rdata is valid
//  bus_rdata      in   32  read data
// BEHAVIOUR
//  Reset: state IDLE; all registers are 0.
//   Outputs after reset: memory_ready=1; memory_valid, bus_req, bus_we, access_fault = 0;
//   bus_wstrb=0; read_word, load_data = 0.
//  Size: force_word ? word : access_type[1:0]. misaligned_exception is driven in every state.
//  States:
//   IDLE: memory_ready=1.
//    memory_enable && !misaligned_exception -> latch cmd/addr/data/size/ext, go REQ.
//    memory_enable && misaligned_exception -> request ignored, stay IDLE.
//    No bus activity in either case.
//   REQ: bus_req=1; bus_we, bus_addr, bus_wstrb, bus_wdata are stable from latched values.
//    bus_gnt -> WAIT.
//    bus_gnt && bus_rsp_valid in the same cycle -> RESP directly; rdata is captured.
//   WAIT: bus_req=0; timeout counter runs.
//    bus_rsp_valid -> capture bus_rdata, go RESP.
//    Counter reaches RESPONSE_TIMEOUT -> set fault flag, clear data, go RESP.
//    The timeout counter also runs in REQ; on expiry bus_req drops.
//   RESP: memory_valid=1 for exactly one cycle; access_fault=fault flag; go IDLE.
//    memory_ready=0 in this cycle.
//  Latency: enable in cycle 0; bus_req in cycle 1. With gnt+rsp in cycle 1, memory_valid in cycle 2.
//  Strobes by size:
//   byte: wstrb=1<<addr[1:0], wdata={4{wd[7:0]}}
//   half: wstrb=addr[1]?1100:0011, wdata={2{wd[15:0]}}
//   word: wstrb=1111, wdata=wd
//  Loads: select lane by addr[1:0] (half by addr[1]); sign-extend unless ext bit set.
//   Word size passes through. read_word is always the unshifted word.
//  Writes: bus_rsp_valid is the ack; read_word and load_data are don't-care (driven 0).
//  memory_enable/inputs outside IDLE are ignored; no queueing.
//  A bus_rsp_valid arriving in IDLE or REQ without gnt is ignored.
//  Reset mid-transaction: return to IDLE next cycle; bus_req drops; no memory_valid issued.
// TESTING
//  1. Fetch, force_word=1, addr 0x100, gnt+rsp same cycle, rdata 0x00500093
//     -> memory_valid in cycle 2; read_word=0x00500093.
//  2. LB addr 0x203 (type 000), rdata 0x80FF1234 -> load_data 0xFFFFFF80.
//     Same with LBU (type 100) -> 0x00000080.
//  3. SH addr 0x12, wd 0xABCD5678 -> bus_addr 0x10, wstrb 1100, wdata 0x56785678;
//     memory_valid after ack.
//  4. LW addr 0x6 -> misaligned_exception=1; no bus_req; memory_ready stays 1.
//  5. gnt delayed 3 cycles, rsp 5 cycles later -> bus_req held 4 cycles; single memory_valid pulse.
//  6. No rsp for 64 cycles -> access_fault=1 with memory_valid, load_data 0;
//     reset during WAIT -> IDLE, bus_req 0, no pulse.

Source files
------------

// File: rtl/memory_access_unit.sv
//------------------------------------------------------------------------------
// Module      : memory_access_unit
// Description : Single-outstanding bridge from the core controller to a
//               word-aligned memory bus with byte strobes and load extension.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module memory_access_unit #(
    parameter int unsigned RESPONSE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_enable,
    input  logic        memory_command,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  access_type,
    input  logic        force_word,
    output logic        memory_ready,
    output logic        memory_valid,
    output logic [31:0] read_word,
    output logic [31:0] load_data,
    output logic        access_fault,
    output logic        misaligned_exception,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int unsigned TW     = (RESPONSE_TIMEOUT > 1) ? $clog2(RESPONSE_TIMEOUT + 1) : 1;
    localparam int unsigned C_TLIM_I = (RESPONSE_TIMEOUT > 0) ? RESPONSE_TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] C_TLIM = TW'(C_TLIM_I);
    localparam logic        C_TEN  = (RESPONSE_TIMEOUT != 0);

    logic [1:0]    state_q, state_d;
    logic          cmd_q, cmd_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          ext_q, ext_d;
    logic          fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [1:0]    w_size;
    logic          w_expired;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    // Instruction fetches always move a full word regardless of funct3.
    always_comb begin
        w_size = SZ_WORD;
        if (!force_word && !access_type[1]) begin
            w_size = access_type[0] ? SZ_HALF : SZ_BYTE;
        end
    end

    assign misaligned_exception = ((w_size == SZ_HALF) && address[0]) ||
                                  ((w_size == SZ_WORD) && (address[1:0] != 2'b00));

    assign w_expired = C_TEN && (timer_q == C_TLIM);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            ext_q   <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            ext_q   <= ext_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        ext_d   = ext_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        timer_d = '0;
        case (state_q)
            S_IDLE: begin
                if (memory_enable && !misaligned_exception) begin
                    state_d = S_REQ;
                    cmd_d   = memory_command;
                    addr_d  = address;
                    wdata_d = write_data;
                    size_d  = w_size;
                    ext_d   = access_type[2];
                    fault_d = 1'b0;
                end
            end
            S_REQ: begin
                timer_d = timer_q + TW'(C_TEN);
                if (bus_gnt && bus_rsp_valid) begin
                    state_d = S_RESP;
                    rdata_d = cmd_q ? 32'd0 : bus_rdata;
                end else if (bus_gnt) begin
                    state_d = S_WAIT;
                end else if (w_expired) begin
                    state_d = S_RESP;
                    fault_d = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(C_TEN);
                if (bus_rsp_valid) begin
                    state_d = S_RESP;
                    rdata_d = cmd_q ? 32'd0 : bus_rdata;
                end else if (w_expired) begin
                    state_d = S_RESP;
                    fault_d = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs
    always_comb begin
        memory_ready = (state_q == S_IDLE);
        memory_valid = (state_q == S_RESP);
        access_fault = (state_q == S_RESP) && fault_q;
        bus_req      = (state_q == S_REQ);
        bus_we       = (state_q == S_REQ) && cmd_q;
    end

    // Bus write lanes and load extraction
    always_comb begin
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_wstrb = 4'b0000;
        case (size_q)
            SZ_BYTE: bus_wdata = {4{wdata_q[7:0]}};
            SZ_HALF: bus_wdata = {2{wdata_q[15:0]}};
            default: bus_wdata = wdata_q;
        endcase
        if ((state_q == S_REQ) && cmd_q) begin
            case (size_q)
                SZ_BYTE: bus_wstrb = 4'b0001 << addr_q[1:0];
                SZ_HALF: bus_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                default: bus_wstrb = 4'b1111;
            endcase
        end

        case (addr_q[1:0])
            2'd0:    w_byte = rdata_q[7:0];
            2'd1:    w_byte = rdata_q[15:8];
            2'd2:    w_byte = rdata_q[23:16];
            default: w_byte = rdata_q[31:24];
        endcase
        w_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

        read_word = rdata_q;
        case (size_q)
            SZ_BYTE: load_data = {{24{w_byte[7] & ~ext_q}}, w_byte};
            SZ_HALF: load_data = {{16{w_half[15] & ~ext_q}}, w_half};
            default: load_data = rdata_q;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_access_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_memory_access_unit
// Description : Randomized self-checking bench for memory_access_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_memory_access_unit;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_enable;
    logic        memory_command;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [2:0]  access_type;
    logic        force_word;
    logic        memory_ready;
    logic        memory_valid;
    logic [31:0] read_word;
    logic [31:0] load_data;
    logic        access_fault;
    logic        misaligned_exception;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    memory_access_unit #(.RESPONSE_TIMEOUT(TMO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .memory_enable        (memory_enable),
        .memory_command       (memory_command),
        .address              (address),
        .write_data           (write_data),
        .access_type          (access_type),
        .force_word           (force_word),
        .memory_ready         (memory_ready),
        .memory_valid         (memory_valid),
        .read_word            (read_word),
        .load_data            (load_data),
        .access_fault         (access_fault),
        .misaligned_exception (misaligned_exception),
        .bus_req              (bus_req),
        .bus_we               (bus_we),
        .bus_addr             (bus_addr),
        .bus_wstrb            (bus_wstrb),
        .bus_wdata            (bus_wdata),
        .bus_gnt              (bus_gnt),
        .bus_rsp_valid        (bus_rsp_valid),
        .bus_rdata            (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes and the rules derived from it
    function automatic int nbytes(input logic fw, input logic [2:0] at);
        if (fw || at[1]) return 4;
        return at[0] ? 2 : 1;
    endfunction

    function automatic logic is_mis(input logic [31:0] a, input logic fw, input logic [2:0] at);
        return (int'(a[1:0]) % nbytes(fw, at)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic fw, input logic [2:0] at);
        int          n;
        logic [31:0] v;
        logic [31:0] mask;
        n = nbytes(fw, at);
        if (n == 4) return rd;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rd >> (8 * int'(a[1:0]))) & mask;
        if (!at[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic fw, input logic [2:0] at);
        int n;
        n = nbytes(fw, at);
        return 4'((1 << n) - 1) << a[1:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic fw, input logic [2:0] at);
        int          n;
        logic [31:0] r;
        n = nbytes(fw, at);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    // One request: gd = cycles before grant, rd = cycles from grant to response
    task automatic txn(input logic cmd, input logic [31:0] a, input logic [2:0] at, input logic fw,
                       input logic [31:0] wd, input int gd, input int rd, input logic [31:0] rdata,
                       input logic stray);
        logic m;
        m = is_mis(a, fw, at);
        chk("ready_idle", memory_ready, 1);
        memory_enable  = 1'b1;
        memory_command = cmd;
        address        = a;
        access_type    = at;
        force_word     = fw;
        write_data     = wd;
        #1;
        chk("misaligned", misaligned_exception, m);
        tick();
        if (m) begin
            memory_enable = 1'b0;
            chk("mis_no_req", bus_req, 0);
            chk("mis_ready", memory_ready, 1);
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            memory_enable = 1'($urandom_range(0, 1));
            address       = $urandom;
            write_data    = $urandom;
            chk("req", bus_req, 1);
            chk("req_notready", memory_ready, 0);
            chk("req_novalid", memory_valid, 0);
            chk("bus_addr", bus_addr, {a[31:2], 2'b00});
            chk("bus_we", bus_we, cmd);
            chk("bus_wstrb", bus_wstrb, cmd ? exp_strb(a, fw, at) : 4'b0000);
            if (cmd) chk("bus_wdata", bus_wdata, exp_wdata(wd, fw, at));
            if (k == gd) begin
                bus_gnt = 1'b1;
                bus_rsp_valid = (rd == 0);
                bus_rdata = rdata;
            end else begin
                bus_gnt = 1'b0;
                bus_rsp_valid = stray && 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
            tick();
            bus_gnt = 1'b0;
            bus_rsp_valid = 1'b0;
        end
        for (int j = 1; j <= rd; j++) begin
            memory_enable = 1'($urandom_range(0, 1));
            chk("wait_noreq", bus_req, 0);
            chk("wait_novalid", memory_valid, 0);
            bus_rsp_valid = (j == rd);
            bus_rdata = (j == rd) ? rdata : 32'($urandom);
            tick();
            bus_rsp_valid = 1'b0;
        end
        memory_enable = 1'b0;
        chk("valid", memory_valid, 1);
        chk("resp_notready", memory_ready, 0);
        chk("no_fault", access_fault, 0);
        chk("read_word", read_word, cmd ? 32'd0 : rdata);
        chk("load_data", load_data, cmd ? 32'd0 : exp_load(rdata, a, fw, at));
        tick();
        chk("valid_pulse", memory_valid, 0);
        chk("ready_after", memory_ready, 1);
    endtask

    // Read that never gets a response; optionally granted first
    task automatic tmo_test(input logic give_gnt);
        int cyc;
        chk("tmo_ready", memory_ready, 1);
        memory_enable = 1'b1;
        memory_command = 1'b0;
        address = 32'h0000_0040;
        force_word = 1'b1;
        access_type = 3'b000;
        tick();
        memory_enable = 1'b0;
        chk("tmo_req", bus_req, 1);
        bus_gnt = give_gnt;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_gnt = 1'b0;
        cyc = 2;
        while (!memory_valid && cyc < 200) begin
            if (!give_gnt && cyc < TMO) chk("tmo_req_held", bus_req, 1);
            tick();
            cyc++;
        end
        chk("tmo_cycle", 32'(cyc), TMO + 1);
        chk("tmo_fault", access_fault, 1);
        chk("tmo_load", load_data, 0);
        chk("tmo_word", read_word, 0);
        chk("tmo_noreq", bus_req, 0);
        tick();
        chk("tmo_pulse", memory_valid, 0);
        chk("tmo_fault_pulse", access_fault, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        memory_enable = 1'b0;
        memory_command = 1'b0;
        address = '0;
        write_data = '0;
        access_type = '0;
        force_word = 1'b0;
        bus_gnt = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ready", memory_ready, 1);
        chk("rst_valid", memory_valid, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_fault", access_fault, 0);
        chk("rst_wstrb", bus_wstrb, 0);
        chk("rst_word", read_word, 0);
        chk("rst_load", load_data, 0);

        // Directed cases
        txn(1'b0, 32'h100, 3'b000, 1'b1, 32'h0, 0, 0, 32'h0050_0093, 1'b0);
        txn(1'b0, 32'h203, 3'b000, 1'b0, 32'h0, 0, 1, 32'h80FF_1234, 1'b0);
        txn(1'b0, 32'h203, 3'b100, 1'b0, 32'h0, 0, 1, 32'h80FF_1234, 1'b0);
        txn(1'b1, 32'h12,  3'b001, 1'b0, 32'hABCD_5678, 0, 2, 32'h0, 1'b0);
        txn(1'b0, 32'h6,   3'b010, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0);
        tick();
        chk("mis_ready_hold", memory_ready, 1);
        chk("mis_noreq_hold", bus_req, 0);
        txn(1'b0, 32'h2A2, 3'b001, 1'b0, 32'h0, 3, 5, 32'h8765_4321, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic        cmd;
            logic        fw;
            logic [31:0] a;
            cmd = 1'($urandom_range(0, 1));
            fw  = !cmd && ($urandom_range(0, 3) == 0);
            a   = $urandom;
            if ($urandom_range(0, 1)) a[1:0] = 2'b00;
            txn(cmd, a, 3'($urandom_range(0, 7)), fw, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'b1);
        end

        txn(1'b0, 32'h300, 3'b010, 1'b0, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
        tmo_test(1'b1);
        tmo_test(1'b0);

        // Reset while waiting for a response
        memory_enable = 1'b1;
        memory_command = 1'b0;
        address = 32'h400;
        access_type = 3'b010;
        force_word = 1'b0;
        tick();
        memory_enable = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_ready", memory_ready, 1);
        chk("rstw_req", bus_req, 0);
        chk("rstw_valid", memory_valid, 0);
        for (int i = 0; i < 4; i++) begin
            bus_rsp_valid = 1'b1;
            bus_rdata = $urandom;
            tick();
            chk("rstw_no_pulse", memory_valid, 0);
        end
        bus_rsp_valid = 1'b0;
        txn(1'b0, 32'h502, 3'b101, 1'b0, 32'h0, 1, 1, 32'hC3A5_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
